// File: rtl/riscv_mc_pkg.sv
// Shared types and constants for the multicycle RISC-V control unit.
// The TRAP state exists only when RISCV_MC_ILLEGAL_TRAP_EN is defined.
package riscv_mc_pkg;

  typedef enum logic [3:0] {
    S_INIT,
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXEC_R,
    S_EXEC_I,
    S_ALUWB,
    S_BRANCH,
    S_JAL
`ifdef RISCV_MC_ILLEGAL_TRAP_EN
    , S_TRAP
`endif
  } state_t;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_NOR = 4'd12;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] MTR_ALUOUT = 2'b00;
  localparam logic [1:0] MTR_MDR    = 2'b01;
  localparam logic [1:0] MTR_PC     = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_A     = 2'b01;
  localparam logic [1:0] SRCA_OLDPC = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;

  // Complete set of datapath controls decoded from the current state.
  typedef struct packed {
    logic       pc_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [3:0] alu_ctl;
    logic       illegal;
  } ctl_t;

  // Where an unsupported instruction goes: parked in TRAP, or dropped as a NOP.
  function automatic state_t illegal_next();
`ifdef RISCV_MC_ILLEGAL_TRAP_EN
    return S_TRAP;
`else
    return S_FETCH;
`endif
  endfunction

endpackage

// File: rtl/riscv_mc_if.sv
// Control-unit bus: instruction fields and status in, datapath controls out.
// master = control unit, slave = datapath / instruction register side.
interface riscv_mc_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic [1:0] mem_to_reg;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_source;
  logic [3:0] alu_ctl;
  logic       illegal;

  modport master (
    input  opcode, funct3, funct7b5, zero, mem_ready,
    output pc_write, iord, mem_read, mem_write, ir_write, reg_write,
           mem_to_reg, alu_src_a, alu_src_b, pc_source, alu_ctl, illegal
  );

  modport slave (
    output opcode, funct3, funct7b5, zero, mem_ready,
    input  pc_write, iord, mem_read, mem_write, ir_write, reg_write,
           mem_to_reg, alu_src_a, alu_src_b, pc_source, alu_ctl, illegal
  );
endinterface

// File: rtl/riscv_alu_decoder.sv
// Maps funct3/funct7b5 to the ALU operation for R-type and I-type arithmetic.
// Unsupported funct3 codes raise 'unsupported' and fall back to ADD.
module riscv_alu_decoder
  import riscv_mc_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       is_rtype,
  output logic [3:0] alu_ctl,
  output logic       unsupported
);

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    alu_ctl     = ALU_ADD;
    unsupported = 1'b0;
    case (funct3)
      3'b000:  alu_ctl = (is_rtype && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b111:  alu_ctl = ALU_AND;
      3'b110:  alu_ctl = ALU_OR;
      3'b010:  alu_ctl = ALU_SLT;
      default: unsupported = 1'b1;
    endcase
  end

endmodule

// File: rtl/riscv_mc_control.sv
// Multicycle RISC-V control FSM: Moore decode of state plus mem_ready/zero.
// Define RISCV_MC_ILLEGAL_TRAP_EN to park unsupported instructions in TRAP.
module riscv_mc_control
  import riscv_mc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  riscv_mc_if.master  bus
);

  state_t     state, state_next;
  ctl_t       ctl;
  logic [3:0] dec_alu_ctl;
  logic       dec_unsupported;

  riscv_alu_decoder u_alu_decoder (
    .funct3      (bus.funct3),
    .funct7b5    (bus.funct7b5),
    .is_rtype    (bus.opcode == OP_RTYPE),
    .alu_ctl     (dec_alu_ctl),
    .unsupported (dec_unsupported)
  );

  // NOTE: sequential state uses non-blocking assignment; the comb block below uses blocking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_INIT;
    else        state <= state_next;
  end

  always_comb begin
    ctl         = '0;
    ctl.alu_ctl = ALU_ADD;
    state_next  = state;
    case (state)
      S_INIT: begin
        ctl.alu_ctl = '0;
        state_next  = S_FETCH;
      end
      S_FETCH: begin
        ctl.mem_read  = 1'b1;
        ctl.alu_src_a = SRCA_PC;
        ctl.alu_src_b = SRCB_FOUR;
        ctl.pc_source = PCSRC_ALU;
        ctl.ir_write  = bus.mem_ready;
        ctl.pc_write  = bus.mem_ready;
        if (bus.mem_ready) state_next = S_DECODE;
      end
      S_DECODE: begin
        // ALUOut captures OldPC+imm here as the branch/jump target.
        ctl.alu_src_a = SRCA_OLDPC;
        ctl.alu_src_b = SRCB_IMM;
        case (bus.opcode)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_RTYPE:          state_next = S_EXEC_R;
          OP_ITYPE:          state_next = S_EXEC_I;
          OP_BRANCH:         state_next = S_BRANCH;
          OP_JAL:            state_next = S_JAL;
          default:           state_next = illegal_next();
        endcase
      end
      S_MEMADR: begin
        ctl.alu_src_a = SRCA_A;
        ctl.alu_src_b = SRCB_IMM;
        state_next    = (bus.opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        ctl.mem_read = 1'b1;
        ctl.iord     = 1'b1;
        if (bus.mem_ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = MTR_MDR;
        state_next     = S_FETCH;
      end
      S_MEMWR: begin
        ctl.mem_write = 1'b1;
        ctl.iord      = 1'b1;
        if (bus.mem_ready) state_next = S_FETCH;
      end
      S_EXEC_R: begin
        ctl.alu_src_a = SRCA_A;
        ctl.alu_src_b = SRCB_B;
        ctl.alu_ctl   = dec_alu_ctl;
        state_next    = dec_unsupported ? illegal_next() : S_ALUWB;
      end
      S_EXEC_I: begin
        ctl.alu_src_b = SRCB_IMM;
        ctl.alu_ctl   = dec_alu_ctl;
        state_next    = dec_unsupported ? illegal_next() : S_ALUWB;
      end
      S_ALUWB: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = MTR_ALUOUT;
        state_next     = S_FETCH;
      end
      S_BRANCH: begin
        ctl.alu_src_a = SRCA_A;
        ctl.alu_src_b = SRCB_B;
        ctl.alu_ctl   = ALU_SUB;
        ctl.pc_source = PCSRC_ALUOUT;
        state_next    = S_FETCH;
        case (bus.funct3)
          3'b000:  ctl.pc_write = bus.zero;
          3'b001:  ctl.pc_write = ~bus.zero;
          default: state_next   = illegal_next();
        endcase
      end
      S_JAL: begin
        ctl.pc_write   = 1'b1;
        ctl.pc_source  = PCSRC_ALUOUT;
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = MTR_PC;
        state_next     = S_FETCH;
      end
`ifdef RISCV_MC_ILLEGAL_TRAP_EN
      S_TRAP: begin
        ctl.alu_ctl = '0;
        ctl.illegal = 1'b1;
        state_next  = S_TRAP;
      end
`endif
      default: begin
        ctl.alu_ctl = '0;
        state_next  = S_INIT;
      end
    endcase
  end

  assign bus.pc_write   = ctl.pc_write;
  assign bus.iord       = ctl.iord;
  assign bus.mem_read   = ctl.mem_read;
  assign bus.mem_write  = ctl.mem_write;
  assign bus.ir_write   = ctl.ir_write;
  assign bus.reg_write  = ctl.reg_write;
  assign bus.mem_to_reg = ctl.mem_to_reg;
  assign bus.alu_src_a  = ctl.alu_src_a;
  assign bus.alu_src_b  = ctl.alu_src_b;
  assign bus.pc_source  = ctl.pc_source;
  assign bus.alu_ctl    = ctl.alu_ctl;
  assign bus.illegal    = ctl.illegal;

endmodule

// File: tb/tb_riscv_mc_control.sv
// Bench for riscv_mc_control: builds the expected per-cycle output trace of each
// instruction from its class and stall counts, then replays it against the DUT.
module tb_riscv_mc_control;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  riscv_mc_if bus ();

  riscv_mc_control dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic       pc_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [3:0] alu_ctl;
    logic       illegal;
  } outs_t;

  typedef struct packed {
    logic  mr;
    logic  z;
    outs_t exp;
  } step_t;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    int         fs;
    int         ms;
    logic       z;
  } instr_t;

  step_t q[$];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic outs_t observe();
    outs_t o;
    o.pc_write   = bus.pc_write;
    o.iord       = bus.iord;
    o.mem_read   = bus.mem_read;
    o.mem_write  = bus.mem_write;
    o.ir_write   = bus.ir_write;
    o.reg_write  = bus.reg_write;
    o.mem_to_reg = bus.mem_to_reg;
    o.alu_src_a  = bus.alu_src_a;
    o.alu_src_b  = bus.alu_src_b;
    o.pc_source  = bus.pc_source;
    o.alu_ctl    = bus.alu_ctl;
    o.illegal    = bus.illegal;
    return o;
  endfunction

  function automatic outs_t o_idle();
    outs_t o = '0;
    o.alu_ctl = 4'd2;
    return o;
  endfunction

  function automatic instr_t mk(logic [6:0] op, logic [2:0] f3, logic f7,
                                int fs, int ms, logic z);
    instr_t i;
    i.op = op; i.f3 = f3; i.f7 = f7; i.fs = fs; i.ms = ms; i.z = z;
    return i;
  endfunction

  function automatic void push(logic mr, logic z, outs_t e);
    step_t s;
    s.mr = mr; s.z = z; s.exp = e;
    q.push_back(s);
  endfunction

  // Reference ALU map for arithmetic instructions.
  function automatic void ref_alu(input logic [2:0] f3, input logic f7, input bit rtype,
                                  output logic [3:0] alu, output bit ok);
    ok  = 1'b1;
    alu = 4'd2;
    case (f3)
      3'b000:  alu = (rtype && f7) ? 4'd6 : 4'd2;
      3'b111:  alu = 4'd0;
      3'b110:  alu = 4'd1;
      3'b010:  alu = 4'd7;
      default: ok = 1'b0;
    endcase
  endfunction

  function automatic void add_fetch(int stalls);
    outs_t o = o_idle();
    o.mem_read  = 1'b1;
    o.alu_src_b = 2'b01;
    for (int k = 0; k < stalls; k++) push(1'b0, rbit(), o);
    o.ir_write = 1'b1;
    o.pc_write = 1'b1;
    push(1'b1, rbit(), o);
  endfunction

  function automatic void add_mem(bit wr, int stalls);
    outs_t o = o_idle();
    o.iord = 1'b1;
    if (wr) o.mem_write = 1'b1;
    else    o.mem_read  = 1'b1;
    for (int k = 0; k < stalls; k++) push(1'b0, rbit(), o);
    push(1'b1, rbit(), o);
  endfunction

  // Appends the expected trace of one instruction; returns 1 if it is unsupported.
  function automatic bit build(instr_t ins);
    outs_t o;
    logic [3:0] alu;
    bit ok;
    bit bad = 1'b0;
    add_fetch(ins.fs);
    o = o_idle(); o.alu_src_a = 2'b10; o.alu_src_b = 2'b10;
    push(rbit(), rbit(), o);
    case (ins.op)
      7'b0000011, 7'b0100011: begin
        o = o_idle(); o.alu_src_a = 2'b01; o.alu_src_b = 2'b10;
        push(rbit(), rbit(), o);
        add_mem(ins.op == 7'b0100011, ins.ms);
        if (ins.op == 7'b0000011) begin
          o = o_idle(); o.reg_write = 1'b1; o.mem_to_reg = 2'b01;
          push(rbit(), rbit(), o);
        end
      end
      7'b0110011, 7'b0010011: begin
        ref_alu(ins.f3, ins.f7, ins.op == 7'b0110011, alu, ok);
        o = o_idle(); o.alu_ctl = alu;
        if (ins.op == 7'b0110011) begin o.alu_src_a = 2'b01; o.alu_src_b = 2'b00; end
        else o.alu_src_b = 2'b10;
        push(rbit(), rbit(), o);
        if (ok) begin
          o = o_idle(); o.reg_write = 1'b1;
          push(rbit(), rbit(), o);
        end else bad = 1'b1;
      end
      7'b1100011: begin
        o = o_idle(); o.alu_src_a = 2'b01; o.alu_ctl = 4'd6; o.pc_source = 2'b01;
        if (ins.f3 == 3'b000)      o.pc_write = ins.z;
        else if (ins.f3 == 3'b001) o.pc_write = ~ins.z;
        else bad = 1'b1;
        push(rbit(), ins.z, o);
      end
      7'b1101111: begin
        o = o_idle(); o.pc_write = 1'b1; o.pc_source = 2'b01;
        o.reg_write = 1'b1; o.mem_to_reg = 2'b10;
        push(rbit(), rbit(), o);
      end
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  task automatic run_steps(input string name);
    outs_t got;
    for (int i = 0; i < q.size(); i++) begin
      bus.mem_ready = q[i].mr;
      bus.zero      = q[i].z;
      #1;
      got = observe();
      n_checks++;
      if (got !== q[i].exp) begin
        n_fail++;
        $display("FAIL %s step %0d: got %h expected %h", name, i, got, q[i].exp);
      end
      @(posedge clk); #1;
    end
    q.delete();
  endtask

  task automatic run_instr(input string name, input instr_t ins);
    bit bad;
    q.delete();
    bus.opcode   = ins.op;
    bus.funct3   = ins.f3;
    bus.funct7b5 = ins.f7;
    bad = build(ins);
`ifdef RISCV_MC_ILLEGAL_TRAP_EN
    if (bad) begin
      outs_t t = '0;
      t.illegal = 1'b1;
      for (int k = 0; k < 5; k++) push(rbit(), rbit(), t);
    end
`else
    if (bad) ; // unsupported instruction falls straight back into fetch
`endif
    run_steps(name);
  endtask

  // Called at posedge+1: holds reset for two cycles, then checks the INIT cycle.
  task automatic do_reset(input string name);
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus.mem_ready = rbit();
      bus.zero      = rbit();
      #1;
      n_checks++;
      if (observe() !== outs_t'(0)) begin
        n_fail++;
        $display("FAIL %s in_reset: got %h expected %h", name, observe(), outs_t'(0));
      end
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    q.delete();
    push(rbit(), rbit(), outs_t'(0));
    run_steps({name, "_init"});
  endtask

  task automatic test_reset();
    do_reset("reset");
    run_instr("add", mk(7'b0110011, 3'b000, 1'b0, 0, 0, 1'b0));
  endtask

  task automatic test_rtype();
    run_instr("sub", mk(7'b0110011, 3'b000, 1'b1, 0, 0, 1'b0));
    run_instr("slt", mk(7'b0110011, 3'b010, 1'b0, 1, 0, 1'b1));
    run_instr("and", mk(7'b0110011, 3'b111, 1'b0, 2, 0, 1'b0));
    run_instr("or",  mk(7'b0110011, 3'b110, 1'b1, 0, 0, 1'b1));
    run_instr("addi_f7", mk(7'b0010011, 3'b000, 1'b1, 0, 0, 1'b0));
    run_instr("slti",    mk(7'b0010011, 3'b010, 1'b0, 1, 0, 1'b0));
  endtask

  task automatic test_mem();
    run_instr("lw_stall3", mk(7'b0000011, 3'b010, 1'b0, 0, 3, 1'b0));
    run_instr("lw",        mk(7'b0000011, 3'b010, 1'b0, 0, 0, 1'b1));
    run_instr("sw",        mk(7'b0100011, 3'b010, 1'b0, 0, 0, 1'b0));
    run_instr("sw_stall2", mk(7'b0100011, 3'b010, 1'b0, 1, 2, 1'b1));
  endtask

  task automatic test_branch_jal();
    run_instr("beq_z1", mk(7'b1100011, 3'b000, 1'b0, 0, 0, 1'b1));
    run_instr("beq_z0", mk(7'b1100011, 3'b000, 1'b0, 0, 0, 1'b0));
    run_instr("bne_z1", mk(7'b1100011, 3'b001, 1'b0, 0, 0, 1'b1));
    run_instr("bne_z0", mk(7'b1100011, 3'b001, 1'b0, 0, 0, 1'b0));
    run_instr("jal",    mk(7'b1101111, 3'b101, 1'b1, 1, 0, 1'b1));
  endtask

  task automatic test_illegal();
    instr_t bads[3];
    bads[0] = mk(7'b0000000, 3'b000, 1'b0, 0, 0, 1'b0);
    bads[1] = mk(7'b0110011, 3'b001, 1'b0, 0, 0, 1'b0);
    bads[2] = mk(7'b1100011, 3'b100, 1'b0, 0, 0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      run_instr($sformatf("illegal%0d", i), bads[i]);
`ifdef RISCV_MC_ILLEGAL_TRAP_EN
      do_reset($sformatf("trap_exit%0d", i));
`else
      run_instr($sformatf("after_illegal%0d", i), mk(7'b0110011, 3'b000, 1'b0, 0, 0, 1'b0));
`endif
    end
  endtask

  task automatic test_reset_mid_memwr();
    outs_t z0 = '0;
    void'(build(mk(7'b0100011, 3'b010, 1'b0, 0, 5, 1'b0)));
    bus.opcode = 7'b0100011; bus.funct3 = 3'b010; bus.funct7b5 = 1'b0;
    while (q.size() > 5) void'(q.pop_back());
    run_steps("sw_pre_reset");
    bus.mem_ready = 1'b0;
    #1;
    n_checks++;
    if (bus.mem_write !== 1'b1) begin
      n_fail++;
      $display("FAIL memwr_before_reset: mem_write got %b expected 1", bus.mem_write);
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (observe() !== z0) begin
      n_fail++;
      $display("FAIL async_reset_memwr: got %h expected %h", observe(), z0);
    end
    @(posedge clk); #1;
    do_reset("reset_after_memwr");
    run_instr("add_after_reset", mk(7'b0110011, 3'b000, 1'b0, 0, 0, 1'b0));
  endtask

  task automatic test_random();
    logic [2:0] alu_f3[4] = '{3'b000, 3'b111, 3'b110, 3'b010};
    logic [6:0] op;
    logic [2:0] f3;
    for (int n = 0; n < 80; n++) begin
      int kind = $urandom_range(0, 9);
      f3 = 3'($urandom);
      case (kind)
        0, 1:    op = 7'b0110011;
        2, 3:    op = 7'b0010011;
        4:       op = 7'b0000011;
        5:       op = 7'b0100011;
        6, 7:    op = 7'b1100011;
        8:       op = 7'b1101111;
        default: begin
          op = 7'b0110011;
`ifndef RISCV_MC_ILLEGAL_TRAP_EN
          do op = 7'($urandom);
          while (op == 7'b0000011 || op == 7'b0100011 || op == 7'b0110011 ||
                 op == 7'b0010011 || op == 7'b1100011 || op == 7'b1101111);
`endif
        end
      endcase
      if (op == 7'b0110011 || op == 7'b0010011) f3 = alu_f3[$urandom_range(0, 3)];
      if (op == 7'b1100011) f3 = {2'b00, rbit()};
      run_instr($sformatf("rand%0d", n),
                mk(op, f3, rbit(), $urandom_range(0, 2), $urandom_range(0, 2), rbit()));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.opcode = '0; bus.funct3 = '0; bus.funct7b5 = 1'b0;
    bus.zero = 1'b0; bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_rtype();
    test_mem();
    test_branch_jal();
    test_illegal();
    test_reset_mid_memwr();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_mc_control.md
# riscv_mc_control

Multicycle control unit for the RISC-V CPU: a Moore-style FSM that sequences each instruction through fetch, decode, execute, memory and write-back, and drives the 4-bit ALU operation code and all datapath mux/enable signals. It consumes the ALU's Zero flag for branch resolution and a memory ready handshake. It sits between the instruction register and the multicycle datapath.

## Interface
- No parameters.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `opcode`  in  7  instr[6:0] from the instruction register.
- `funct3`  in  3  instr[14:12].
- `funct7b5`  in  1  instr[30].
- `zero`  in  1  ALU Zero flag, 1 when the ALU result is 0.
- `mem_ready`  in  1  memory completed the current read or write this cycle.
- `pc_write`  out  1  PC register load enable.
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `mem_read`, `mem_write`  out  1  memory request strobes, held until `mem_ready`.
- `ir_write`  out  1  instruction register and OldPC load.
- `reg_write`  out  1  register file write enable.
- `mem_to_reg`  out  2  write-back select: 00 ALUOut, 01 MDR, 10 PC.
- `alu_src_a`  out  2  00 PC, 01 A register, 10 OldPC.
- `alu_src_b`  out  2  00 B register, 01 constant 4, 10 immediate.
- `pc_source`  out  2  00 ALU result, 01 ALUOut register.
- `alu_ctl`  out  4  0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT, 12 NOR.
- `illegal`  out  1  unsupported instruction flag.

## Operation
- States: INIT, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, EXEC_I, ALUWB, BRANCH, JAL, TRAP.
- INIT: all outputs 0, `alu_ctl`=0. Unconditional transition to FETCH.
- FETCH:
  - `mem_read`=1, `iord`=0, `alu_src_a`=00, `alu_src_b`=01, `alu_ctl`=ADD, `pc_source`=00.
  - `ir_write` and `pc_write` equal `mem_ready`.
  - Stays in FETCH while `mem_ready`=0, otherwise goes to DECODE.
- DECODE: `alu_src_a`=10, `alu_src_b`=10, ADD, so ALUOut receives OldPC+imm as the branch/jump target. Next state by opcode:
  - 0000011 and 0100011 → MEMADR
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 1100011 → BRANCH
  - 1101111 → JAL
  - anything else → illegal path (see Configuration).
- MEMADR: `alu_src_a`=01, `alu_src_b`=10, ADD. Goes to MEMRD for load, MEMWR for store.
- MEMRD: `mem_read`=1, `iord`=1. Waits for `mem_ready`, then goes to MEMWB.
- MEMWB: `reg_write`=1, `mem_to_reg`=01. Goes to FETCH.
- MEMWR: `mem_write`=1, `iord`=1. Waits for `mem_ready`, then goes to FETCH.
- EXEC_R: `alu_src_a`=01, `alu_src_b`=00. `alu_ctl` from funct3:
  - 000 → ADD, or SUB when `funct7b5`=1
  - 111 → AND
  - 110 → OR
  - 010 → SLT
  - Any other funct3 takes the illegal path. Otherwise goes to ALUWB.
- EXEC_I: `alu_src_b`=10, same funct3 map with `funct7b5` ignored (000 is always ADD). Goes to ALUWB.
- ALUWB: `reg_write`=1, `mem_to_reg`=00. Goes to FETCH.
- BRANCH: `alu_src_a`=01, `alu_src_b`=00, SUB, `pc_source`=01.
  - funct3 000 (beq): `pc_write`=`zero`.
  - funct3 001 (bne): `pc_write`=~`zero`.
  - Any other funct3 takes the illegal path.
  - Goes to FETCH.
- JAL: `pc_write`=1, `pc_source`=01, `reg_write`=1, `mem_to_reg`=10 (PC already holds OldPC+4). Goes to FETCH.
- Outputs not listed for a state are 0; `alu_ctl` defaults to ADD.

## Timing
- State is registered; every output is a combinational decode of the state, plus `mem_ready` and `zero` where stated.
- Reset: asserting `rst_n` at any time, including mid-memory-wait, forces INIT immediately. Every output reads 0 during and one cycle after reset.
- Cycle counts with `mem_ready` tied high:
  - R-type and I-type: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch and JAL: 3 cycles.
- Each cycle `mem_ready` is low adds one cycle in FETCH, MEMRD or MEMWR.
- `mem_ready` seen outside a memory state is ignored.
- `mem_read` and `mem_write` are never asserted in the same cycle.
- `zero` is sampled only in BRANCH.

## Configuration
- `RISCV_MC_ILLEGAL_TRAP_EN` defined:
  - The illegal path enters TRAP.
  - TRAP asserts `illegal`=1 with all other outputs 0.
  - TRAP is held until reset.
- Undefined:
  - The illegal path returns directly to FETCH, so the instruction is executed as a NOP.
  - `illegal` is tied to 0.
  - The TRAP state is absent.

## Structure
- Package `riscv_mc_pkg` holds:
  - the state enum;
  - the ALU control constants (AND/OR/ADD/SUB/SLT/NOR);
  - the opcode constants;
  - the mux-select constants for `mem_to_reg`, `alu_src_a`, `alu_src_b` and `pc_source`.
- Sub-module `riscv_alu_decoder`: combinational map from (funct3, `funct7b5`, is_rtype) to `alu_ctl` plus an unsupported flag. It is instantiated once, in the FSM.

## Test plan
- Reset, then add (opcode 0110011, funct3 000, `funct7b5`=0), `mem_ready`=1 → state sequence INIT, FETCH, DECODE, EXEC_R, ALUWB; `alu_ctl`=2 in EXEC_R; `reg_write`=1 only in ALUWB.
- sub then slt (`funct7b5`=1 / funct3 010) → `alu_ctl`=6 then 7 in EXEC_R.
- lw with `mem_ready` low for 3 cycles in MEMRD → MEMRD held 4 cycles with `mem_read`=1 and `iord`=1; MEMWB `mem_to_reg`=01.
- beq with `zero`=1 → `pc_write`=1 and `pc_source`=01. bne with `zero`=1 → `pc_write`=0.
- Opcode 0000000 → with the macro, `illegal`=1 held until `rst_n` low; without it, the next state is FETCH.
- `rst_n` pulsed low mid-MEMWR → `mem_write` drops asynchronously; restart from INIT.
